// File: rtl/nco_mixer_pkg.sv
// Shared types and helpers for the NCO mixer: FSM state encoding, default
// widths and the common saturation function.
package nco_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_NCO = 2'd1,
        RUN      = 2'd2
    } state_t;

    localparam int DEF_DW    = 12;
    localparam int DEF_MPR   = 10;
    localparam int DEF_OW    = 16;
    localparam int DEF_SHIFT = 5;
    localparam int PW        = DEF_DW + DEF_MPR;

    // Clip a sign-extended value into the signed range of an ow-bit word.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] value,
                                                     input int unsigned       ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        return value;
    endfunction

endpackage

// File: rtl/mixer_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of the
// full-precision mixer product down to the output width.
module mixer_round_sat #(
    parameter int PW    = nco_mixer_pkg::PW,
    parameter int SHIFT = nco_mixer_pkg::DEF_SHIFT,
    parameter int OW    = nco_mixer_pkg::DEF_OW
) (
    input  logic signed [PW-1:0] p_i,
    output logic signed [OW-1:0] r_o,
    output logic                 sat_o
);
    import nco_mixer_pkg::*;

    // One guard bit so adding the rounding constant cannot wrap.
    localparam logic signed [PW:0] HALF = {{PW{1'b0}}, 1'b1} << (SHIFT - 1);

    logic signed [PW:0]   sum;
    logic signed [PW:0]   shr;
    logic signed [63:0]   ext;
    logic signed [OW-1:0] clip;

    // Round, shift, then clip into the output range.
    always_comb begin
        sum  = {p_i[PW-1], p_i} + HALF;
        shr  = sum >>> SHIFT;
        ext  = 64'(shr);
        clip = OW'(sat_clip(ext, OW));
    end

    assign r_o   = clip;
    assign sat_o = (64'(clip) != ext);

endmodule

// File: rtl/nco_mixer_rt.sv
// Real mixer behind the NCO: multiplies samples by the NCO sine word, rounds
// and saturates over a two-stage pipeline, and tracks NCO readiness.
// Optional feature macro NCO_MIXER_SATCNT_EN adds a saturating clip counter.
module nco_mixer_rt
    import nco_mixer_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int MPR   = DEF_MPR,
    parameter int OW    = DEF_OW,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clken_i,
    input  logic signed [DW-1:0]  din_i,
    input  logic                  din_valid_i,
    input  logic signed [MPR-1:0] nco_sin_i,
    input  logic                  nco_valid_i,
    output logic signed [OW-1:0]  dout_o,
    output logic                  dout_valid_o,
    output logic                  sat_o,
    output logic                  run_o
`ifdef NCO_MIXER_SATCNT_EN
    ,
    output logic [15:0]           sat_cnt_o
`endif
);
    localparam int PWL = DW + MPR;

    state_t                state_q, state_d;
    logic                  v1_q;
    logic signed [PWL-1:0] p_q, p_d;
    logic signed [OW-1:0]  dout_q;
    logic                  sat_q;
    logic                  dv_q;
    logic                  accept;
    logic                  flush;
    logic                  out_ok;
    logic signed [OW-1:0]  r_rs;
    logic                  sat_rs;

    // Next-state logic: leave IDLE on the first enabled cycle, then follow nco_valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = WAIT_NCO;
            WAIT_NCO: if (nco_valid_i) state_d = RUN;
            RUN:      if (!nco_valid_i) state_d = WAIT_NCO;
            default:  state_d = IDLE;
        endcase
    end

    assign run_o  = (state_q == RUN);
    assign accept = run_o & din_valid_i & nco_valid_i;
    // Losing the NCO kills everything still in flight so stale phase never leaks out.
    assign flush  = run_o & ~nco_valid_i;
    assign out_ok = v1_q & ~flush;
    assign p_d    = PWL'(din_i) * PWL'(nco_sin_i);

    mixer_round_sat #(
        .PW    (PWL),
        .SHIFT (SHIFT),
        .OW    (OW)
    ) u_round_sat (
        .p_i   (p_q),
        .r_o   (r_rs),
        .sat_o (sat_rs)
    );

    // FSM state and both pipeline stages; everything freezes while clken is low.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            v1_q    <= 1'b0;
            p_q     <= '0;
            dout_q  <= '0;
            sat_q   <= 1'b0;
            dv_q    <= 1'b0;
        end else if (clken_i) begin
            state_q <= state_d;
            v1_q    <= accept;
            if (accept)
                p_q <= p_d;
            dv_q    <= out_ok;
            if (out_ok) begin
                dout_q <= r_rs;
                sat_q  <= sat_rs;
            end
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dv_q;
    assign sat_o        = sat_q;

`ifdef NCO_MIXER_SATCNT_EN
    logic [15:0] sat_cnt_q;

    // Count clipped output samples, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            sat_cnt_q <= '0;
        else if (clken_i && out_ok && sat_rs && (sat_cnt_q != 16'hFFFF))
            sat_cnt_q <= sat_cnt_q + 16'd1;
    end

    assign sat_cnt_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_nco_mixer_rt.sv
// Self-checking bench for nco_mixer_rt: directed corners plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_nco_mixer_rt;
    localparam int DW = 12, MPR = 10, OW = 16, SHIFT = 5;

    logic                  clk = 1'b0;
    logic                  reset, clken, din_valid, nco_valid;
    logic signed [DW-1:0]  din;
    logic signed [MPR-1:0] nco_sin;
    logic signed [OW-1:0]  dout;
    logic                  dout_valid, sat, run;
`ifdef NCO_MIXER_SATCNT_EN
    logic [15:0]           sat_cnt;
`endif

    nco_mixer_rt #(.DW(DW), .MPR(MPR), .OW(OW), .SHIFT(SHIFT)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .clken_i      (clken),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .nco_sin_i    (nco_sin),
        .nco_valid_i  (nco_valid),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .sat_o        (sat),
        .run_o        (run)
`ifdef NCO_MIXER_SATCNT_EN
        ,
        .sat_cnt_o    (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: exact product, floor((p + half) / 2^SHIFT), clip to OW bits.
    function automatic longint ref_mix(input longint a, input longint b, output bit s);
        longint x, q, dv, hi, lo;
        dv = longint'(2) ** SHIFT;
        x  = a * b + dv / 2;
        if (x >= 0) q = x / dv;
        else        q = -((-x + dv - 1) / dv);
        hi = (longint'(2) ** (OW - 1)) - 1;
        lo = -(longint'(2) ** (OW - 1));
        s  = 1'b0;
        if (q > hi)      begin q = hi; s = 1'b1; end
        else if (q < lo) begin q = lo; s = 1'b1; end
        return q;
    endfunction

    // Model state: mode 0=idle 1=waiting for NCO 2=running; one sample in flight.
    int     m_mode = 0;
    bit     m_fl_v = 0, m_fl_sat = 0, m_ov = 0, m_sat = 0;
    longint m_fl_val = 0, m_dout = 0;
    longint m_cnt = 0;
    longint cap[$];
    bit     cap_sat[$];

    task automatic step(input bit rst, input bit ce, input bit dv, input longint d,
                        input bit nv, input longint s);
        bit running;
        reset = rst; clken = ce; din_valid = dv; nco_valid = nv;
        din = d[DW-1:0]; nco_sin = s[MPR-1:0];
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_fl_v = 0; m_ov = 0; m_dout = 0; m_sat = 0; m_cnt = 0;
        end else if (ce) begin
            running = (m_mode == 2);
            m_ov = m_fl_v && !(running && !nv);
            if (m_ov) begin
                m_dout = m_fl_val; m_sat = m_fl_sat;
                if (m_sat && m_cnt < 65535) m_cnt++;
            end
            m_fl_v = running && dv && nv;
            if (m_fl_v) m_fl_val = ref_mix(d, s, m_fl_sat);
            if (m_mode == 0) m_mode = 1;
            else             m_mode = nv ? 2 : 1;
        end
        #1;
        chk("dout_valid", dout_valid, m_ov);
        chk("dout", dout, m_dout);
        chk("sat", sat, m_sat);
        chk("run", run, longint'(m_mode == 2));
`ifdef NCO_MIXER_SATCNT_EN
        chk("sat_cnt", sat_cnt, m_cnt);
`endif
        if (ce && !rst && dout_valid) begin
            cap.push_back(dout);
            cap_sat.push_back(sat);
        end
    endtask

    task automatic restart();
        step(1, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
    endtask

    longint ed[4] = '{1, -1, 32767, -32752};
    bit     es[4] = '{0, 0, 1, 0};
    longint sd[4] = '{3, -3, -2048, 2047};
    longint sn[4] = '{11, 11, -512, -512};
    longint rd[24], rn[24], capa[$];

    initial begin
        reset = 1; clken = 1; din_valid = 1; nco_valid = 1; din = '0; nco_sin = '0;

        // Reset held with traffic present: everything stays cleared.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 5, 1, 7);
            chk("rst_dout", dout, 0);
            chk("rst_run", run, 0);
        end
        step(0, 1, 1, 5, 1, 7);
        chk("run_one_after", run, 0);
        step(0, 1, 0, 0, 1, 0);
        chk("run_two_after", run, 1);

        // Directed values including the only overflowing corner.
        cap.delete(); cap_sat.delete();
        for (int i = 0; i < 4; i++) step(0, 1, 1, sd[i], 1, sn[i]);
        step(0, 1, 0, 0, 1, 0);
        chk("dir_lat", dout_valid, 1);
        step(0, 1, 0, 0, 1, 0);
        chk("dir_count", cap.size(), 4);
        for (int i = 0; i < 4 && i < cap.size(); i++) begin
            chk("dir_dout", cap[i], ed[i]);
            chk("dir_sat", cap_sat[i], es[i]);
        end

        // Same stream at full rate and with clken toggling must match exactly.
        for (int i = 0; i < 24; i++) begin
            rd[i] = longint'($urandom_range(0, 4095)) - 2048;
            rn[i] = longint'($urandom_range(0, 1023)) - 512;
        end
        restart(); cap.delete(); cap_sat.delete();
        for (int i = 0; i < 24; i++) step(0, 1, 1, rd[i], 1, rn[i]);
        repeat (3) step(0, 1, 0, 0, 1, 0);
        capa = cap;
        restart(); cap.delete(); cap_sat.delete();
        for (int i = 0; i < 24; i++) begin
            step(0, 1, 1, rd[i], 1, rn[i]);
            step(0, 0, 1, longint'($urandom_range(0, 4095)) - 2048, 1, 77);
        end
        repeat (3) begin step(0, 1, 0, 0, 1, 0); step(0, 0, 0, 0, 1, 0); end
        chk("stretch_count", cap.size(), capa.size());
        for (int i = 0; i < capa.size() && i < cap.size(); i++)
            chk("stretch_dout", cap[i], capa[i]);

        // One-cycle NCO drop mid-stream.
        restart(); cap.delete(); cap_sat.delete();
        for (int i = 0; i < 5; i++) step(0, 1, 1, 100 + i, 1, 3);
        step(0, 1, 1, 200, 0, 3);
        chk("drop_run", run, 0);
        chk("drop_flush", dout_valid, 0);
        step(0, 1, 1, 201, 1, 3);
        chk("drop_run_back", run, 1);
        step(0, 1, 1, 300, 1, 3);
        chk("recover_gap", dout_valid, 0);
        step(0, 1, 1, 301, 1, 3);
        chk("recover_lat", dout_valid, 1);
        step(0, 1, 1, 302, 1, 3);
        step(0, 1, 1, 303, 1, 3);
        repeat (2) step(0, 1, 0, 0, 1, 0);
        chk("drop_count", cap.size(), 8);

        // Randomized traffic with sporadic resets, stalls and NCO drops.
        for (int i = 0; i < 3000; i++) begin
            longint d, s;
            d = longint'($urandom_range(0, 4095)) - 2048;
            s = longint'($urandom_range(0, 1023)) - 512;
            if ($urandom_range(0, 9) == 0) begin d = -2048; s = -512; end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 8, d, $urandom_range(0, 19) != 0, s);
        end

`ifdef NCO_MIXER_SATCNT_EN
        restart();
        for (int i = 0; i < 70000; i++) step(0, 1, 1, -2048, 1, -512);
        repeat (2) step(0, 1, 0, 0, 1, 0);
        chk("satcnt_full", sat_cnt, 65535);
        step(1, 1, 0, 0, 1, 0);
        chk("satcnt_rst", sat_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
